x_delay_line_ctrl: RTL



---
 rtl/x_delay_line_ctrl.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/x_delay_line_ctrl.sv
// Sequencer for a delay-line time-to-digital converter.
// Launches an edge into the cell chain, captures it after the resolvers
// settle, shifts the snapshot out serially, and reports the tap word,
// the number of propagated cells and a thermometer-bubble flag.
module x_delay_line_ctrl #(
  parameter int CELLS       = 64,
  parameter int CAPTURE_DLY = 3,
  parameter int CW          = $clog2(CELLS + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  output logic             o_busy,
  output logic             o_launch,
  output logic             o_dl_en,
  output logic             o_shift_en,
  output logic             o_shift_in,
  input  logic             i_shift_out,
  output logic             o_result_valid,
  input  logic             i_result_ready,
  output logic [CELLS-1:0] o_taps,
  output logic [CW-1:0]    o_count,
  output logic             o_bubble
);

  // One counter serves both the launch wait and the shift index.
  localparam int CNT_MAX = (CELLS > CAPTURE_DLY) ? CELLS : CAPTURE_DLY;
  localparam int CNTW    = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LAUNCH  = 3'd1,
    S_CAPTURE = 3'd2,
    S_SHIFT   = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [CELLS-1:0]  taps_q, taps_d;
  logic [CW-1:0]     count_q, count_d;
  logic              bubble_q, bubble_d;
  logic              busy_q, busy_d;
  logic              launch_q, launch_d;
  logic              dl_en_q, dl_en_d;
  logic              shift_en_q, shift_en_d;
  logic              valid_q, valid_d;
  logic              start_acc;
  logic              shift_now;

  assign start_acc = (state_q == S_IDLE) && i_start;
  assign shift_now = (state_q == S_SHIFT);

  // State and sequencing counter register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic. LAUNCH lasts CAPTURE_DLY cycles so that the capture
  // strobe lands CAPTURE_DLY cycles after the first launch-high cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = S_LAUNCH;
          cnt_d   = '0;
        end
      end
      S_LAUNCH: begin
        if (cnt_q == CNTW'(CAPTURE_DLY - 1)) begin
          state_d = S_CAPTURE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_CAPTURE: begin
        state_d = S_SHIFT;
        cnt_d   = '0;
      end
      S_SHIFT: begin
        if (cnt_q == CNTW'(CELLS - 1)) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        if (i_result_ready) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode from the upcoming state so the registered strobes line up
  // with the state they belong to.
  always_comb begin
    busy_d     = (state_d != S_IDLE);
    launch_d   = (state_d == S_LAUNCH) || (state_d == S_CAPTURE);
    dl_en_d    = (state_d == S_CAPTURE);
    shift_en_d = (state_d == S_SHIFT);
    valid_d    = (state_d == S_DONE);
  end

  // Shift cycle k carries cell CELLS-1-k; each tap bit grabs its own cycle.
  genvar gi;
  generate
    for (gi = 0; gi < CELLS; gi++) begin : g_tap
      assign taps_d[gi] = start_acc ? 1'b0 :
                          (shift_now && (cnt_q == CNTW'(CELLS - 1 - gi))) ? i_shift_out :
                          taps_q[gi];
    end
  endgenerate

  // Count and bubble accumulation; a 0 after any 1 in shift order is a bubble.
  always_comb begin
    count_d  = count_q;
    bubble_d = bubble_q;
    if (start_acc) begin
      count_d  = '0;
      bubble_d = 1'b0;
    end else if (shift_now) begin
      count_d = count_q + CW'(i_shift_out);
      if (!i_shift_out && (count_q != '0)) bubble_d = 1'b1;
    end
  end

  // Result and control output registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      taps_q     <= '0;
      count_q    <= '0;
      bubble_q   <= 1'b0;
      busy_q     <= 1'b0;
      launch_q   <= 1'b0;
      dl_en_q    <= 1'b0;
      shift_en_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      taps_q     <= taps_d;
      count_q    <= count_d;
      bubble_q   <= bubble_d;
      busy_q     <= busy_d;
      launch_q   <= launch_d;
      dl_en_q    <= dl_en_d;
      shift_en_q <= shift_en_d;
      valid_q    <= valid_d;
    end
  end

  assign o_busy         = busy_q;
  assign o_launch       = launch_q;
  assign o_dl_en        = dl_en_q;
  assign o_shift_en     = shift_en_q;
  assign o_shift_in     = 1'b0;
  assign o_result_valid = valid_q;
  assign o_taps         = taps_q;
  assign o_count        = count_q;
  assign o_bubble       = bubble_q;

endmodule
